// File: rtl/oserdes_pkg.sv
`default_nettype none
// ============================================================================
// Module  : oserdes_pkg
// Brief   : Shared widths and scheduler state encoding for the serializer front end.
// Rev     : 1.0
// ============================================================================
package oserdes_pkg;

   localparam int LEN_W      = 8;
   localparam int BYTE_W     = 8;
   localparam int CNT_W      = 9;
   localparam int GAP_W      = 4;
   // Extra drain cycles covering the serializer's buffer read latency.
   localparam int SER_RD_LAT = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARB   = 3'd1,
      ST_LOAD  = 3'd2,
      ST_FIRE  = 3'd3,
      ST_DRAIN = 3'd4,
      ST_GAP   = 3'd5
   } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/oserdes_tx_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin pick: first request at or above ptr, with wrap.
// Rev     : 1.0
// ============================================================================
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [PTR_W-1:0]   idx,
   output logic               any
);

   logic [PTR_W-1:0] cand;

   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
         if (!any && req[cand]) begin
            any       = 1'b1;
            idx       = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/oserdes_tx_sched.sv
`default_nettype none
// ============================================================================
// Module  : oserdes_tx_sched
// Brief   : Round-robin burst scheduler sharing one 8:1 serializer among NUM_REQ sources.
// Rev     : 1.0
// ============================================================================
module oserdes_tx_sched
   import oserdes_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int GAP_CYC = 4
) (
   input  logic                      wr_clk,
   input  logic                      wr_rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [LEN_W*NUM_REQ-1:0]  len_in,
   input  logic [BYTE_W*NUM_REQ-1:0] src_data,
   input  logic [NUM_REQ-1:0]        src_valid,
   output logic [NUM_REQ-1:0]        grant,
   output logic [BYTE_W-1:0]         data_out,
   output logic                      data_valid_out,
   output logic                      start,
   output logic [LEN_W-1:0]          length_out,
   output logic [NUM_REQ-1:0]        done,
   output logic                      busy
);

   localparam int PTR_W = $clog2(NUM_REQ);

   sched_state_t          state_q, state_d;
   logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]      win_idx_q, win_idx_d;
   logic [LEN_W-1:0]      len_reg_q, len_reg_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [GAP_W-1:0]      gap_q, gap_d;
   logic [NUM_REQ-1:0]    grant_q, grant_d;
   logic [BYTE_W-1:0]     data_out_q, data_out_d;
   logic                  dvalid_q, dvalid_d;
   logic                  start_q, start_d;
   logic [LEN_W-1:0]      length_q, length_d;
   logic [NUM_REQ-1:0]    done_q, done_d;

   logic [LEN_W-1:0]      len_arr [NUM_REQ];
   logic [BYTE_W-1:0]     src_arr [NUM_REQ];
   logic [NUM_REQ-1:0]    arb_gnt;
   logic [PTR_W-1:0]      arb_idx;
   logic                  arb_any;
   logic [LEN_W-1:0]      arb_len;
   logic                  src_ok;
   logic [NUM_REQ-1:0]    win_oh;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign len_arr[g] = len_in[g*LEN_W +: LEN_W];
      assign src_arr[g] = src_data[g*BYTE_W +: BYTE_W];
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_arb (
      .req (req),
      .ptr (rr_ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   assign arb_len = len_arr[arb_idx];
   assign src_ok  = src_valid[win_idx_q] & grant_q[win_idx_q];
   assign win_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_q;

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      win_idx_d  = win_idx_q;
      len_reg_d  = len_reg_q;
      cnt_d      = cnt_q;
      gap_d      = gap_q;
      grant_d    = grant_q;
      data_out_d = data_out_q;
      length_d   = length_q;
      dvalid_d   = 1'b0;
      start_d    = 1'b0;
      done_d     = '0;

      case (state_q)
         ST_IDLE: begin
            if (|req) state_d = ST_ARB;
         end

         ST_ARB: begin
            if (arb_any) begin
               win_idx_d = arb_idx;
               len_reg_d = arb_len;
               grant_d   = arb_gnt;
               cnt_d     = '0;
               rr_ptr_d  = (arb_idx == PTR_W'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
               // A zero length would make the serializer read a full 256-byte loop,
               // so the burst completes here without ever reaching FIRE.
               if (arb_len == '0) begin
                  done_d  = arb_gnt;
                  gap_d   = GAP_W'(GAP_CYC);
                  state_d = ST_GAP;
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_LOAD: begin
            if (src_ok) begin
               data_out_d = src_arr[win_idx_q];
               dvalid_d   = 1'b1;
               cnt_d      = cnt_q + CNT_W'(1);
               if (cnt_q + CNT_W'(1) == CNT_W'(len_reg_q)) begin
                  grant_d = '0;
                  state_d = ST_FIRE;
               end
            end
         end

         ST_FIRE: begin
            start_d  = 1'b1;
            length_d = len_reg_q;
            cnt_d    = CNT_W'(len_reg_q) + CNT_W'(SER_RD_LAT);
            state_d  = ST_DRAIN;
         end

         ST_DRAIN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               done_d  = win_oh;
               gap_d   = GAP_W'(GAP_CYC);
               state_d = ST_GAP;
            end
         end

         ST_GAP: begin
            grant_d = '0;
            if (gap_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge wr_clk) begin
      if (wr_rst) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         win_idx_q  <= '0;
         len_reg_q  <= '0;
         cnt_q      <= '0;
         gap_q      <= '0;
         grant_q    <= '0;
         data_out_q <= '0;
         dvalid_q   <= 1'b0;
         start_q    <= 1'b0;
         length_q   <= '0;
         done_q     <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         win_idx_q  <= win_idx_d;
         len_reg_q  <= len_reg_d;
         cnt_q      <= cnt_d;
         gap_q      <= gap_d;
         grant_q    <= grant_d;
         data_out_q <= data_out_d;
         dvalid_q   <= dvalid_d;
         start_q    <= start_d;
         length_q   <= length_d;
         done_q     <= done_d;
      end
   end

   assign grant          = grant_q;
   assign data_out       = data_out_q;
   assign data_valid_out = dvalid_q;
   assign start          = start_q;
   assign length_out     = length_q;
   assign done           = done_q;
   assign busy           = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_oserdes_tx_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_oserdes_tx_sched
// Brief   : Randomized bench for oserdes_tx_sched against a burst-timeline reference model.
// Rev     : 1.0
// ============================================================================
module tb_oserdes_tx_sched;

   localparam int N     = 4;
   localparam int G     = 4;
   localparam int NEVER = 1 << 30;

   logic           wr_clk = 1'b0;
   logic           wr_rst = 1'b1;
   logic [N-1:0]   req = '0;
   logic [8*N-1:0] len_in = '0;
   logic [8*N-1:0] src_data = '0;
   logic [N-1:0]   src_valid = '0;
   logic [N-1:0]   grant;
   logic [7:0]     data_out;
   logic           data_valid_out;
   logic           start;
   logic [7:0]     length_out;
   logic [N-1:0]   done;
   logic           busy;

   always #5 wr_clk = ~wr_clk;

   oserdes_tx_sched #(
      .NUM_REQ (N),
      .GAP_CYC (G)
   ) dut (
      .wr_clk         (wr_clk),
      .wr_rst         (wr_rst),
      .req            (req),
      .len_in         (len_in),
      .src_data       (src_data),
      .src_valid      (src_valid),
      .grant          (grant),
      .data_out       (data_out),
      .data_valid_out (data_valid_out),
      .start          (start),
      .length_out     (length_out),
      .done           (done),
      .busy           (busy)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int k     = 0;

   // Pending burst lengths per requester; the front entry is the one on offer.
   int q_len [N][$];
   int bp [N];
   bit fixed_bytes;
   int vprob;
   bit pause_en;
   bit pause_done;
   int pause_left;

   // Reference timeline: edge indices at which each event of the current burst is due.
   int m_ptr, cur, cur_len, last_len;
   int arb_edge, g_edge, start_edge, done_edge, t_idle;
   bit in_load, acc_now;
   logic [7:0] acc_byte;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s edge=%0d got=0x%0h expected=0x%0h", tag, k, got, exp);
      end
   endtask

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      cur        = -1;
      cur_len    = 0;
      in_load    = 1'b0;
      acc_now    = 1'b0;
      m_ptr      = 0;
      last_len   = 0;
      t_idle     = k;
      arb_edge   = 0;
      g_edge     = -10;
      start_edge = -10;
      done_edge  = -10;
      pause_left = 0;
      for (int i = 0; i < N; i++) bp[i] = 0;
   endtask

   task automatic check_cycle();
      logic [N-1:0] eg, ed;
      bit edv;
      logic [7:0] ebyte;
      int c;
      eg    = '0;
      ed    = '0;
      edv   = acc_now;
      ebyte = acc_byte;
      if (acc_now) begin
         bp[cur]++;
         if (bp[cur] == cur_len) begin
            in_load    = 1'b0;
            start_edge = k + 1;
            done_edge  = k + 3 + cur_len;
            t_idle     = done_edge + G + 1;
         end
      end
      acc_now = 1'b0;
      if (k == g_edge) begin
         cur = -1;
         for (int i = 0; i < N; i++) begin
            c = (m_ptr + i) % N;
            if (cur < 0 && req[c]) cur = c;
         end
         if (cur < 0) begin
            t_idle = k;
         end else begin
            m_ptr      = (cur + 1) % N;
            cur_len    = q_len[cur][0];
            bp[cur]    = 0;
            pause_done = 1'b0;
            pause_left = 0;
            if (cur_len == 0) begin
               eg        = oh(cur);
               done_edge = k;
               t_idle    = k + G + 1;
            end else begin
               in_load = 1'b1;
            end
         end
      end
      if (in_load) eg = oh(cur);
      if (k == start_edge) last_len = cur_len;
      if (k == done_edge) begin
         ed = oh(cur);
         void'(q_len[cur].pop_front());
      end
      check_eq("grant", 32'(grant), 32'(eg));
      check_eq("done", 32'(done), 32'(ed));
      check_eq("data_valid_out", 32'(data_valid_out), 32'(edv));
      if (edv) check_eq("data_out", 32'(data_out), 32'(ebyte));
      check_eq("start", 32'(start), 32'(k == start_edge));
      check_eq("length_out", 32'(length_out), 32'(last_len));
      check_eq("busy", 32'(busy), 32'(k >= arb_edge && k < t_idle));
   endtask

   task automatic drive();
      logic [N-1:0] r;
      bit v;
      logic [7:0] d;
      for (int i = 0; i < N; i++) begin
         r[i] = (q_len[i].size() > 0);
         len_in[8*i +: 8] = r[i] ? 8'(q_len[i][0]) : 8'h00;
      end
      req = r;
      if (k >= t_idle && r != '0) begin
         arb_edge = k + 1;
         g_edge   = k + 2;
         t_idle   = NEVER;
      end
      for (int i = 0; i < N; i++) begin
         v = 1'($urandom_range(0, 1));
         d = 8'($urandom);
         if (in_load && i == cur) begin
            v = ($urandom_range(0, 99) < vprob);
            if (pause_en && !pause_done && bp[i] == cur_len / 2) begin
               pause_done = 1'b1;
               pause_left = 5;
            end
            if (pause_left > 0) begin
               v = 1'b0;
               pause_left--;
            end
            if (v && fixed_bytes) d = 8'(8'hA1 + bp[i]);
            acc_now  = v;
            acc_byte = d;
         end
         src_valid[i]       = v;
         src_data[8*i +: 8] = d;
      end
   endtask

   task automatic step();
      @(posedge wr_clk);
      k++;
      @(negedge wr_clk);
      check_cycle();
      drive();
   endtask

   task automatic reset_cycle();
      wr_rst = 1'b1;
      @(posedge wr_clk);
      k++;
      @(negedge wr_clk);
      if (cur >= 0) q_len[cur].delete();
      model_reset();
      check_cycle();
      check_eq("reset_data_out", 32'(data_out), 32'd0);
      wr_rst = 1'b0;
   endtask

   function automatic bit queues_busy();
      for (int i = 0; i < N; i++) if (q_len[i].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic run(input string tag, input int budget);
      int n;
      n = 0;
      while (n < budget && (k < t_idle || queues_busy())) begin
         step();
         n++;
      end
      check_eq({tag, "_completes"}, 32'(n < budget), 32'd1);
   endtask

   initial begin
      int n, s0;
      fixed_bytes = 1'b0;
      vprob       = 100;
      pause_en    = 1'b0;
      pause_done  = 1'b0;
      model_reset();
      @(negedge wr_clk);
      repeat (3) reset_cycle();
      drive();

      // Single requester, fixed bytes A1..A3
      fixed_bytes = 1'b1;
      q_len[0].push_back(3);
      run("single", 200);
      fixed_bytes = 1'b0;

      // All four requesting len 2 twice: strict rotation with wrap
      for (int i = 0; i < N; i++) begin
         q_len[i].push_back(2);
         q_len[i].push_back(2);
      end
      run("rotate", 600);

      q_len[2].push_back(0);
      run("zero_len", 100);

      q_len[1].push_back(255);
      q_len[1].push_back(255);
      run("len255", 2500);

      pause_en = 1'b1;
      q_len[3].push_back(12);
      run("pause", 300);
      pause_en = 1'b0;

      vprob = 70;
      repeat (4) begin
         for (int i = 0; i < N; i++) begin
            q_len[i].push_back(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12)));
         end
      end
      run("random", 4000);

      // Reset in the middle of DRAIN, then a fresh request must start from requester 0
      vprob = 100;
      s0    = start_edge;
      q_len[1].push_back(10);
      n = 0;
      while (n < 500 && !(start_edge != s0 && k == start_edge + 3)) begin
         step();
         n++;
      end
      check_eq("reach_drain", 32'(n < 500), 32'd1);
      reset_cycle();
      drive();
      q_len[2].push_back(2);
      q_len[0].push_back(2);
      run("after_reset", 300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/oserdes_tx_sched.md
# oserdes_tx_sched

Burst scheduler in front of the 8:1 serializer block. It shares that single serializer between `NUM_REQ` byte-stream requesters using round-robin arbitration. For each granted burst it:
- copies exactly `len` bytes from the winner into the serializer's write-side buffer;
- pulses the serializer's `start` with the burst length;
- holds off the next burst until the serializer has drained, plus a guard gap.

It runs entirely in the serializer's parallel-side clock domain.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `GAP_CYC`, 4, idle guard cycles after drain before next arbitration (1..15)

Ports:
- `wr_clk`  in  1  single clock for the whole block
- `wr_rst`  in  1  reset, synchronous, active-high
- `req`  in  NUM_REQ  per-requester burst request, level
- `len_in`  in  8*NUM_REQ  per-requester burst length in bytes, slice i = [8i+7:8i]
- `src_data`  in  8*NUM_REQ  per-requester byte data
- `src_valid`  in  NUM_REQ  per-requester byte valid
- `grant`  out  NUM_REQ  one-hot grant; doubles as the source ready
- `data_out`  out  8  byte to serializer `data_in`
- `data_valid_out`  out  1  to serializer `data_valid_in`
- `start`  out  1  one-cycle pulse to serializer `start`
- `length_out`  out  8  to serializer `length_in`; stable from `start` until the next `start`
- `done`  out  NUM_REQ  one-cycle pulse on the granted bit when its burst completes
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ARB, LOAD, FIRE, DRAIN, GAP.
- IDLE:
  - If any `req` bit is high, go to ARB.
- ARB (1 cycle):
  - Pick the first asserted `req` at or after round-robin pointer `rr_ptr`, scanning upward with wrap.
  - Latch its index and `len_in` slice into `len_reg`, and set `grant` one-hot.
  - Set `rr_ptr` to winner+1 mod NUM_REQ.
  - If `len_reg` is 0: pulse `done`, clear `grant`, go to GAP. The serializer never sees a zero length, because its read loop would then run 256 bytes.
  - Otherwise go to LOAD with `cnt`=0.
- LOAD:
  - Each cycle that `src_valid[winner]` and `grant[winner]` are both high, the byte is accepted.
  - An accepted byte is registered to `data_out`, `data_valid_out` goes high for 1 cycle, and `cnt` increments.
  - Bytes offered by non-granted sources are ignored.
  - When the `len_reg`-th byte is accepted: drop `grant` the next cycle and go to FIRE.
  - `req` deasserting mid-LOAD is ignored. The requester must deliver all `len_reg` bytes; there is no timeout.
- FIRE (1 cycle):
  - `start`=1 and `length_out`=`len_reg`.
  - Go to DRAIN with `cnt` reloaded to `len_reg`+2, which covers the serializer's read latency.
- DRAIN:
  - Decrement `cnt` each cycle.
  - At 0: pulse `done[winner]`, load the GAP counter with `GAP_CYC`, go to GAP.
- GAP:
  - Decrement the counter; at 0, go to IDLE.
  - A `req` bit held high re-arbitrates on the next cycle through IDLE→ARB.
- Buffer pointer consistency: the serializer's write and read addresses both wrap at 256 and advance only on bursts from this block. Loading exactly `len_reg` bytes and then reading exactly `len_reg` keeps the two aligned across wrap.
- Widths:
  - `cnt` is 9 bits, so `len_reg`+2 with `len_reg`=255 gives 257 without overflow.
  - `rr_ptr` is $clog2(NUM_REQ) bits.

## Timing
- Reset values (any cycle, including mid-burst):
  - State IDLE; `grant`, `data_valid_out`, `start`, `done`, `busy` = 0; `data_out`, `length_out` = 0; `rr_ptr`=0.
  - A burst interrupted by reset is abandoned. The serializer is reset by the same `wr_rst`, so its buffer pointers also restart at 0.
- `req` high in IDLE at cycle t: ARB at t+1, `grant` visible at t+2.
- A source byte accepted at cycle t appears on `data_out`/`data_valid_out` at t+1.
- Last byte accepted at t:
  - `grant` low at t+1.
  - `start` at t+2, i.e. after the last RAM write has landed.
- Minimum burst-to-burst spacing for requester A (len L) then B: arb(1)+L+1+1+(L+2)+GAP_CYC+1 cycles from ARB to ARB.
- Simultaneous `req` from all sources: grants rotate strictly. No source is granted twice while another requester is waiting.
- `done` and the following `req` drop may coincide; a `req` still high after `done` is treated as a new burst.

## Structure
- Shared package `oserdes_pkg`:
  - FSM state enum.
  - `LEN_W`=8 and `CNT_W`=9.
  - `SER_RD_LAT`=2, the drain margin.
- One sub-module `rr_arbiter`: request vector plus pointer in, one-hot grant and index out, purely combinational.
- FSM, counters and output registers live in the top module.

## Test plan
- Single requester 0, `len_in`=3, bytes 0xA1,0xA2,0xA3 each with valid → `data_out` shows A1,A2,A3; `start` is 1 cycle with `length_out`=3, 2 cycles after the third accept; `done[0]` fires 5 cycles after `start`.
- All 4 `req` high, len=2 each → grants in order 0,1,2,3,0; `rr_ptr` wraps correctly.
- Requester 2 with `len_in`=0 → `grant[2]` for 1 cycle, `done[2]` pulse, no `start`, no `data_valid_out`.
- `len_in`=255 → 255 writes, `length_out`=255, DRAIN lasts 257 cycles; a second 255-byte burst verifies the serializer output across address wrap.
- Granted source pauses `src_valid` for 5 cycles mid-LOAD while a non-granted source toggles valid → only the granted bytes are written; `start` waits for the final byte.
- `wr_rst` asserted during DRAIN → next cycle all outputs 0, state IDLE; a fresh `req` is served from requester 0.
